// File: rtl/piso_8bit_tx.sv
// Byte serializer: one byte per valid/ready handshake, shifted out MSB-first.
// Optional feature macro: PISO_PARITY_EN adds the registered `parity` output.
module piso_8bit_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       ser_out,
  output logic       busy,
`ifdef PISO_PARITY_EN
  output logic       done,
  output logic       parity
`else
  output logic       done
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic       last_bit;
  logic       load_fire;

  // Handshake: a byte transfers on a rising edge where load_valid && load_ready;
  // load_valid is ignored and data_in is not sampled while load_ready is low.
  assign last_bit   = (state == SHIFT) && (cnt == 3'd7);
  assign load_ready = !rst && ((state == IDLE) || (cnt == 3'd7));
  assign load_fire  = load_valid && load_ready;

  assign ser_out = shreg[7];
  assign busy    = (state == SHIFT);

`ifdef PISO_PARITY_EN
  logic par_pend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= 8'h00;
      cnt   <= 3'd0;
      done  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_pend <= 1'b0;
      parity   <= 1'b0;
`endif
    end else begin
      done <= last_bit;
`ifdef PISO_PARITY_EN
      // Publish the finished byte's parity before a same-edge reload overwrites it.
      if (last_bit) parity <= par_pend;
`endif
      if (load_fire) begin
        shreg <= data_in;
        cnt   <= 3'd0;
        state <= SHIFT;
`ifdef PISO_PARITY_EN
        par_pend <= ^data_in;
`endif
      end else begin
        // Zeros shift in continuously, so an idle line rests at 0.
        shreg <= {shreg[6:0], 1'b0};
        if (state == SHIFT) begin
          if (cnt == 3'd7) state <= IDLE;
          else             cnt   <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_8bit_tx.sv
// Randomized bench for piso_8bit_tx against a bit-queue reference model,
// with a bench-side downstream 8-bit shift register fed from ser_out.
module tb_piso_8bit_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       ser_out;
  logic       busy;
  logic       done;
`ifdef PISO_PARITY_EN
  logic       parity;
`endif

  piso_8bit_tx dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .busy       (busy),
`ifdef PISO_PARITY_EN
    .done       (done),
    .parity     (parity)
`else
    .done       (done)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: bits still to appear on the line, and bytes in flight
  logic       bitq[$];
  logic [7:0] exp_q[$];
  logic       exp_done;
  logic       exp_par;
  logic [7:0] exp_byte;
  logic [7:0] down;
  logic       obs_ser;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, settle, clock edge, model update, check at negedge.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    logic exp_ready;
    logic fire;
    logic tmp;
    logic exp_ser;
    rst        = r;
    load_valid = v;
    data_in    = d;
    #1;
    exp_ready = !r && (bitq.size() <= 1);
    check("load_ready", {7'b0, load_ready}, {7'b0, exp_ready});
    fire = v && exp_ready;
    @(posedge clk);
    exp_done = 1'b0;
    down = {down[6:0], obs_ser};
    if (r) begin
      bitq.delete();
      exp_q.delete();
      exp_par = 1'b0;
    end else begin
      if (bitq.size() > 0) begin
        tmp = bitq.pop_front();
        if (bitq.size() == 0) begin
          exp_done = 1'b1;
          exp_byte = exp_q.pop_front();
          exp_par  = ^exp_byte;
        end
      end
      if (fire) begin
        for (int i = 7; i >= 0; i--) bitq.push_back(d[i]);
        exp_q.push_back(d);
      end
    end
    @(negedge clk);
    exp_ser = (bitq.size() > 0) ? bitq[0] : 1'b0;
    check("ser_out", {7'b0, ser_out}, {7'b0, exp_ser});
    check("busy", {7'b0, busy}, {7'b0, (bitq.size() > 0)});
    check("done", {7'b0, done}, {7'b0, exp_done});
    if (exp_done) check("down_byte", down, exp_byte);
`ifdef PISO_PARITY_EN
    check("parity", {7'b0, parity}, {7'b0, exp_par});
`endif
    obs_ser = ser_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  // mode while waiting for ready: 0 valid low, 1 hold valid with the byte, 2 random junk
  task automatic send(input logic [7:0] b, input int mode);
    logic accepted;
    accepted = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bitq.size() <= 1) begin
        cycle(1'b0, 1'b1, b);
        accepted = 1'b1;
        break;
      end
      case (mode)
        0:       cycle(1'b0, 1'b0, b);
        1:       cycle(1'b0, 1'b1, b);
        default: cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      endcase
    end
    check("send_accepted", {7'b0, accepted}, 8'd1);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_done   = 1'b0;
    exp_par    = 1'b0;
    exp_byte   = 8'h00;
    down       = 8'h00;
    obs_ser    = 1'b0;
    rst        = 1'b1;
    load_valid = 1'b0;
    data_in    = 8'h00;

    // reset, with load_valid high during reset to confirm reset wins
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b0, 8'h00);
    idle(2);

    // single byte
    send(8'hA5, 0);
    idle(10);

    // valid held high, back-to-back
    send(8'h3C, 1);
    send(8'hC3, 1);
    idle(10);

    // reset mid-byte at cnt==4, then a clean byte
    send(8'hFF, 0);
    idle(4);
    cycle(1'b1, 1'b1, 8'h55);
    idle(3);
    send(8'h81, 0);
    idle(10);

    // junk on data_in/load_valid while busy
    send(8'h5A, 0);
    send(8'h96, 2);
    idle(10);

    // parity sequence
    send(8'hA5, 1);
    send(8'h01, 1);
    send(8'h00, 1);
    idle(10);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       idle($urandom_range(1, 4));
        1:       cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        default: send(8'($urandom_range(0, 255)), $urandom_range(0, 2));
      endcase
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
